core_bus_target: RTL and testbench
==================================

Name: core_bus_target

Overview:
- Memory/peripheral responder on the far end of the core's 24-bit-address, 16-bit-data bus.
- Serves the core's Address/WriteData/WriteEnable and returns ReadData.
- Bank 0x00 is a RAM holding instructions and data.
- Bank PERIPH_BANK holds memory-mapped peripherals: status, a TX FIFO drained by a valid/ready sink, an LED register and a free-running cycle counter.

Parameters:
RAM_AW, 10, RAM word-address width; bank 0 holds 2**RAM_AW words.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..128.
PERIPH_BANK, 8'hFF, Address[23:16] value selecting the peripheral bank.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
Address  in  24  [23:16] bank, [15:0] word offset.
WriteData  in  16  store data.
WriteEnable  in  1  write strobe; the write commits at the rising edge while high.
ReadData  out  16  read data, combinational from Address.
tx_data  out  16  FIFO head word.
tx_valid  out  1  FIFO non-empty.
tx_ready  in  1  sink accepts the head when tx_valid && tx_ready at the edge.
led  out  16  LED register.

Behaviour:
- Reset is asynchronous on rst_n low. It clears:
  - the FIFO (empty, pointers 0), overflow, bus_err;
  - led = 0, cycle counter = 0.
  - RAM contents are not reset.
  - ReadData remains a combinational function of Address and state.
- Read timing:
  - Zero-latency combinational read; the core samples ReadData in the same cycle it drives Address.
  - A read in the same cycle as a write to the same location returns the old value.
- Bank 0x00: RAM index = Address[RAM_AW-1:0]; upper offset bits are ignored (aliasing). A write stores WriteData at the edge.
- Bank PERIPH_BANK, offset map:
  - 0x0000 STATUS
    - read: [15:8] fifo count, [7:4] 0, [3] bus_err, [2] overflow, [1] full, [0] empty.
    - write: a 1 in bit 3 clears bus_err; a 1 in bit 2 clears overflow (W1C). Other bits are ignored.
  - 0x0001 TXDATA
    - write: push WriteData.
    - read: 0.
  - 0x0002 LED: read/write; led = register value.
  - 0x0003 CYCLE_LO: read-only, counter[15:0]. Writes are ignored.
  - 0x0004 CYCLE_HI: read-only, counter[31:16]. Writes are ignored.
  - Any other offset reads 0; a write to it sets bus_err.
- Any other bank reads 0; a write to it sets bus_err and is otherwise dropped.
- Cycle counter:
  - 32-bit, increments every clock after reset, wraps 0xFFFFFFFF -> 0.
  - HI/LO are not snapshotted; software reads HI, LO, HI.
- FIFO:
  - Circular buffer with read/write pointers and a count of width $clog2(FIFO_DEPTH)+1.
  - tx_data = entry at the read pointer, registered storage. tx_data is don't-care when empty.
  - pop = tx_valid && tx_ready.
  - push = TXDATA write.
  - Push when not full: the entry is stored.
  - Push when full without pop: dropped, overflow <= 1, contents unchanged.
  - Push and pop in the same cycle when full: both happen, count is unchanged, the new word lands in the freed slot.
  - Push and pop in the same cycle when empty: impossible by construction (pop requires valid). The push is stored, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- Sticky flags:
  - Set has priority over a W1C clear in the same cycle.
  - overflow and bus_err are set only by their events and cleared only by W1C or reset.
- Reset mid-transfer: the FIFO is flushed and tx_valid drops asynchronously. Words not yet accepted are lost.
- WriteData is ignored when WriteEnable is low. An X on WriteData with WriteEnable low must not corrupt state.

Decomposition:
- Shared package holds:
  - bank constants: BANK_RAM = 8'h00;
  - peripheral offsets: OFF_STATUS, OFF_TXDATA, OFF_LED, OFF_CYC_LO, OFF_CYC_HI;
  - STATUS bit indices.
- One natural sub-module, tx_fifo: parameterised FIFO_DEPTH × 16 with push/pop/full/empty/count/overflow outputs.
- Address decode, RAM, registers and counter stay in core_bus_target.

Test Plan:
- RAM round trip:
  - Reset, write 0x1234 to 0x000005.
  - Next cycle, Address=0x000005 -> ReadData=0x1234.
  - Address=0x000405 (alias, RAM_AW=10) -> 0x1234.
- FIFO ordering:
  - tx_ready=0, push 0xA1,0xA2,0xA3,0xA4 to 0xFF0001.
  - STATUS reads 0x0402 (count 4, full). A 5th push 0xA5 -> STATUS 0x0406 (overflow).
  - Raise tx_ready -> tx_data sequence A1,A2,A3,A4, then tx_valid=0, STATUS 0x0005.
- Full push + pop same cycle:
  - FIFO full, tx_ready=1, push 0xB0 in the same edge.
  - Count stays 4, overflow stays 0, 0xB0 emerges after A4.
- Bus error and W1C:
  - Write to 0x120000 -> STATUS bit3=1.
  - Write 0x0008 to 0xFF0000 -> bit3=0.
  - Write 0x0008 to 0xFF0000 in the same cycle as a write to bad bank 0x120000 is impossible on a single bus, so instead: write 0xFF0007 (unmapped) -> bit3=1.
- LED/counter:
  - Write 0xBEEF to 0xFF0002 -> led=0xBEEF, read back 0xBEEF.
  - CYCLE_LO read 10 cycles after reset release = 10; CYCLE_HI = 0.
- Async reset mid-stream:
  - 3 words queued, tx_valid=1; pulse rst_n low between edges.
  - tx_valid=0, led=0 immediately; STATUS=0x0001 after release.

Source files
------------

// File: rtl/core_bus_target_pkg.sv
// rtl/core_bus_target_pkg.sv - shared bus widths, bank/offset map and STATUS layout
package core_bus_target_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    localparam logic [7:0] BANK_RAM = 8'h00;

    localparam logic [15:0] OFF_STATUS = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0001;
    localparam logic [15:0] OFF_LED    = 16'h0002;
    localparam logic [15:0] OFF_CYC_LO = 16'h0003;
    localparam logic [15:0] OFF_CYC_HI = 16'h0004;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_BUS_ERR  = 3;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_PERIPH,
        RGN_NONE
    } region_e;

    function automatic logic [15:0] status_word(
        input logic [7:0] count,
        input logic       bus_err,
        input logic       overflow,
        input logic       full,
        input logic       empty
    );
        logic [15:0] w;
        w                = '0;
        w[15:8]          = count;
        w[ST_BUS_ERR]    = bus_err;
        w[ST_OVERFLOW]   = overflow;
        w[ST_FULL]       = full;
        w[ST_EMPTY]      = empty;
        return w;
    endfunction

endpackage

// File: rtl/core_bus_target_if.sv
// rtl/core_bus_target_if.sv - core bus plus TX stream bundle with core/target views
interface core_bus_target_if;
    import core_bus_target_pkg::*;

    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              WriteEnable;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output Address, WriteData, WriteEnable, tx_ready,
        input  ReadData, tx_data, tx_valid
    );

    modport slave (
        input  Address, WriteData, WriteEnable, tx_ready,
        output ReadData, tx_data, tx_valid
    );

endinterface

// File: rtl/core_bus_target_tx_fifo.sv
// rtl/core_bus_target_tx_fifo.sv - circular TX FIFO with sticky overflow flag
module core_bus_target_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_ready,
    input  logic                     i_ovf_clr,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_ready;
    // A pop in the same edge frees the slot the push lands in.
    assign w_wr    = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_data     = r_mem[r_rptr];
    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/core_bus_target.sv
// rtl/core_bus_target.sv - RAM bank plus peripheral bank (STATUS, TX FIFO, LED, cycle counter)
module core_bus_target
    import core_bus_target_pkg::*;
#(
    parameter int         RAM_AW      = 10,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] PERIPH_BANK = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    core_bus_target_if.slave      bus,
    output logic [DATA_W-1:0]     led
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         w_bank;
    logic [15:0]        w_off;
    region_e            w_region;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_wr_ram;
    logic               w_wr_per;
    logic               w_off_mapped;
    logic               w_push;
    logic               w_led_we;
    logic               w_st_we;
    logic               w_berr_set;
    logic               w_berr_clr;
    logic               w_ovf_clr;

    logic               w_full;
    logic               w_empty;
    logic               w_overflow;
    logic [CNT_W-1:0]   w_count;

    logic [DATA_W-1:0]  r_ram [2**RAM_AW];
    logic [DATA_W-1:0]  r_led;
    logic               r_bus_err;
    logic [31:0]        r_cycle;

    assign w_bank    = bus.Address[23:16];
    assign w_off     = bus.Address[15:0];
    assign w_ram_idx = bus.Address[RAM_AW-1:0];

    always_comb begin
        w_region = RGN_NONE;
        if (w_bank == BANK_RAM) begin
            w_region = RGN_RAM;
        end else if (w_bank == PERIPH_BANK) begin
            w_region = RGN_PERIPH;
        end
    end

    // Every write effect is gated by WriteEnable so garbage on WriteData is harmless.
    assign w_wr_ram     = bus.WriteEnable && (w_region == RGN_RAM);
    assign w_wr_per     = bus.WriteEnable && (w_region == RGN_PERIPH);
    assign w_off_mapped = (w_off <= OFF_CYC_HI);
    assign w_push       = w_wr_per && (w_off == OFF_TXDATA);
    assign w_led_we     = w_wr_per && (w_off == OFF_LED);
    assign w_st_we      = w_wr_per && (w_off == OFF_STATUS);
    assign w_berr_set   = bus.WriteEnable &&
                          ((w_region == RGN_NONE) || ((w_region == RGN_PERIPH) && !w_off_mapped));
    assign w_berr_clr   = w_st_we && bus.WriteData[ST_BUS_ERR];
    assign w_ovf_clr    = w_st_we && bus.WriteData[ST_OVERFLOW];

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led     <= '0;
            r_bus_err <= 1'b0;
            r_cycle   <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_led_we) begin
                r_led <= bus.WriteData;
            end
            if (w_berr_set) begin
                r_bus_err <= 1'b1;
            end else if (w_berr_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    core_bus_target_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_data     (bus.WriteData),
        .i_ready    (bus.tx_ready),
        .i_ovf_clr  (w_ovf_clr),
        .o_data     (bus.tx_data),
        .o_valid    (bus.tx_valid),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    always_comb begin
        bus.ReadData = '0;
        case (w_region)
            RGN_RAM: bus.ReadData = r_ram[w_ram_idx];
            RGN_PERIPH: begin
                case (w_off)
                    OFF_STATUS: bus.ReadData = status_word(8'(w_count), r_bus_err,
                                                           w_overflow, w_full, w_empty);
                    OFF_LED:    bus.ReadData = r_led;
                    OFF_CYC_LO: bus.ReadData = r_cycle[15:0];
                    OFF_CYC_HI: bus.ReadData = r_cycle[31:16];
                    default:    bus.ReadData = '0;
                endcase
            end
            default: bus.ReadData = '0;
        endcase
    end

    assign led = r_led;

endmodule

// File: tb/tb_core_bus_target.sv
// tb/tb_core_bus_target.sv - directed plus randomized checks against a behavioural bus model
module tb_core_bus_target;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] led;

    core_bus_target_if bus();

    core_bus_target #(
        .RAM_AW      (10),
        .FIFO_DEPTH  (DEPTH),
        .PERIPH_BANK (8'hFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    logic [15:0] m_ram [1024];
    bit          m_vld [1024];
    logic [15:0] m_q [$];
    logic        m_ovf;
    logic        m_berr;
    logic [15:0] m_led;
    logic [31:0] m_cyc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] rd_seen;
    logic [15:0] tx_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_berr = 1'b0;
        m_led  = 16'h0;
        m_cyc  = 32'h0;
    endfunction

    function automatic logic [15:0] m_read(input logic [23:0] a, output bit known);
        logic [7:0]  bank;
        logic [15:0] off;
        logic [9:0]  idx;
        bank  = a[23:16];
        off   = a[15:0];
        idx   = a[9:0];
        known = 1'b1;
        if (bank == 8'h00) begin
            known = m_vld[idx];
            return m_ram[idx];
        end
        if (bank != 8'hFF) return 16'h0;
        case (off)
            16'd0: return {8'(m_q.size()), 4'b0000, m_berr, m_ovf,
                           (m_q.size() == DEPTH), (m_q.size() == 0)};
            16'd2: return m_led;
            16'd3: return m_cyc[15:0];
            16'd4: return m_cyc[31:16];
            default: return 16'h0;
        endcase
    endfunction

    function automatic void model_step(input logic [23:0] a, input logic [15:0] wd,
                                       input bit we, input bit rdy);
        logic [7:0]  bank;
        logic [15:0] off;
        logic [15:0] popped;
        bit          ovf_set, berr_set, st_wr;
        bank     = a[23:16];
        off      = a[15:0];
        ovf_set  = 1'b0;
        st_wr    = we && bank == 8'hFF && off == 16'd0;
        berr_set = we && ((bank != 8'h00 && bank != 8'hFF) || (bank == 8'hFF && off > 16'd4));
        if (m_q.size() != 0 && rdy) popped = m_q.pop_front();
        if (we && bank == 8'hFF && off == 16'd1) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
            else ovf_set = 1'b1;
        end
        if (we && bank == 8'h00) begin
            m_ram[a[9:0]] = wd;
            m_vld[a[9:0]] = 1'b1;
        end
        if (we && bank == 8'hFF && off == 16'd2) m_led = wd;
        m_ovf  = ovf_set  ? 1'b1 : ((st_wr && wd[2]) ? 1'b0 : m_ovf);
        m_berr = berr_set ? 1'b1 : ((st_wr && wd[3]) ? 1'b0 : m_berr);
        m_cyc  = m_cyc + 32'd1;
    endfunction

    task automatic do_cycle(input logic [23:0] a, input logic [15:0] wd, input bit we, input bit rdy);
        logic [15:0] exp;
        bit          known;
        @(negedge clk);
        bus.Address     = a;
        bus.WriteData   = wd;
        bus.WriteEnable = we;
        bus.tx_ready    = rdy;
        #1;
        exp     = m_read(a, known);
        rd_seen = bus.ReadData;
        tx_seen = bus.tx_data;
        if (known) check("rdata", bus.ReadData, exp);
        check("tx_valid", bus.tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("tx_data", bus.tx_data, m_q[0]);
        check("led", led, m_led);
        @(posedge clk);
        #1;
        model_step(a, wd, we, rdy);
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_led", led, 16'h0);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    logic [15:0] seq_a [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    logic [15:0] seq_c [5] = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4, 16'h00B0};

    initial begin
        rst_n           = 1'b0;
        bus.Address     = '0;
        bus.WriteData   = '0;
        bus.WriteEnable = 1'b0;
        bus.tx_ready    = 1'b0;
        for (int i = 0; i < 1024; i++) m_vld[i] = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_valid", bus.tx_valid, 1'b0);
        check("reset_led", led, 16'h0);
        rst_n = 1'b1;

        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("reset_status", rd_seen, 16'h0001);

        do_cycle(24'h000005, 16'h1234, 1'b1, 1'b0);
        do_cycle(24'h000005, 16'h0, 1'b0, 1'b0);
        check("ram_rt", rd_seen, 16'h1234);
        do_cycle(24'h000405, 16'h0, 1'b0, 1'b0);
        check("ram_alias", rd_seen, 16'h1234);

        for (int i = 0; i < 4; i++) do_cycle(24'hFF0001, seq_a[i], 1'b1, 1'b0);
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("st_full", rd_seen, 16'h0402);
        do_cycle(24'hFF0001, 16'h00A5, 1'b1, 1'b0);
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("st_ovf", rd_seen, 16'h0406);
        for (int i = 0; i < 4; i++) begin
            do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b1);
            check("pop_order", tx_seen, seq_a[i]);
        end
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("st_drained", rd_seen, 16'h0005);
        check("drained_valid", bus.tx_valid, 1'b0);
        do_cycle(24'hFF0000, 16'h0004, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) do_cycle(24'hFF0001, seq_c[i], 1'b1, 1'b0);
        do_cycle(24'hFF0001, 16'h00B0, 1'b1, 1'b1);
        check("pushpop_head", tx_seen, seq_c[0]);
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("st_pushpop", rd_seen, 16'h0402);
        for (int i = 1; i < 5; i++) begin
            do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b1);
            check("pushpop_order", tx_seen, seq_c[i]);
        end

        do_cycle(24'h120000, 16'h5555, 1'b1, 1'b0);
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("berr_bank", rd_seen, 16'h0009);
        do_cycle(24'hFF0000, 16'h0008, 1'b1, 1'b0);
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("berr_w1c", rd_seen, 16'h0001);
        do_cycle(24'hFF0007, 16'h1111, 1'b1, 1'b0);
        do_cycle(24'hFF0000, 16'h0008, 1'b1, 1'b0);
        check("berr_unmapped", rd_seen, 16'h0009);

        do_cycle(24'hFF0002, 16'hBEEF, 1'b1, 1'b0);
        do_cycle(24'hFF0002, 16'h0, 1'b0, 1'b0);
        check("led_out", led, 16'hBEEF);
        check("led_read", rd_seen, 16'hBEEF);

        for (int i = 0; i < 3; i++) do_cycle(24'hFF0001, 16'(16'h0D00 + i), 1'b1, 1'b0);
        check("queued_valid", bus.tx_valid, 1'b1);
        pulse_reset();
        do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        check("post_rst_status", rd_seen, 16'h0001);
        for (int i = 0; i < 9; i++) do_cycle(24'hFF0000, 16'h0, 1'b0, 1'b0);
        do_cycle(24'hFF0003, 16'h0, 1'b0, 1'b0);
        check("cyc_lo", rd_seen, 16'd10);
        do_cycle(24'hFF0004, 16'h0, 1'b0, 1'b0);
        check("cyc_hi", rd_seen, 16'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [23:0] a;
            logic [15:0] wd;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                a = {8'h00, 6'($urandom_range(0, 63)), 10'($urandom_range(0, 15))};
            end else if (sel < 9) begin
                a = {8'hFF, 16'($urandom_range(0, 7))};
            end else begin
                a = {8'($urandom_range(1, 254)), 16'($urandom)};
            end
            wd = 16'($urandom);
            do_cycle(a, wd, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
